mem_tgl_master: RTL and testbench

//  Initiator side of the toggle req/ack memory handshake used by the dual-port memory arbiter
//  (port B: a request is pending while req != ack).
//  - Accepts read/write commands from a coprocessor core through a valid/ready FIFO.
//  - Issues one transaction at a time to the arbiter and returns read data as a one-cycle pulse.
//  - Sits between a coprocessor core (SVP-class) and the arbiter's mem_*_b port.

---
 rtl/mem_tgl_master.sv | 160 ++++++++++++++++
 tb/tb_mem_tgl_master.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_tgl_master.sv
// Toggle req/ack memory initiator: command FIFO feeding one outstanding arbiter transaction.
// Optional watchdog enabled by defining MEM_TGL_TIMEOUT_EN.
module mem_tgl_master #(
  parameter int unsigned AW        = 20,
  parameter int unsigned DW        = 16,
  parameter int unsigned FIFO_LOG2 = 2,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_vld,
  output logic          cmd_rdy,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_dat,
  output logic          rsp_vld,
  output logic [DW-1:0] rsp_dat,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dat,
  output logic          mem_wr,
  output logic          mem_req,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdat,
  output logic          busy,
  output logic          err_timeout
);

  localparam int unsigned Depth = 2 ** FIFO_LOG2;
  localparam int unsigned EntW  = 1 + AW + DW;

  typedef enum logic [1:0] {StSync, StIdle, StWait} state_e;

  state_e               state_q, state_d;
  logic [EntW-1:0]      fifo_q [Depth];
  logic [FIFO_LOG2:0]   wr_ptr_q, rd_ptr_q;
  logic                 empty, full, push, pop;
  logic                 mem_req_q, mem_req_d, mem_wr_q, mem_wr_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic [DW-1:0]        mem_dat_q, mem_dat_d, rsp_dat_q, rsp_dat_d;
  logic                 rsp_vld_q, rsp_vld_d;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_LOG2] != rd_ptr_q[FIFO_LOG2]) &&
                 (wr_ptr_q[FIFO_LOG2-1:0] == rd_ptr_q[FIFO_LOG2-1:0]);
  assign cmd_rdy = !full;
  assign push    = cmd_vld && !full;

`ifdef MEM_TGL_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_wr_d   = mem_wr_q;
    mem_addr_d = mem_addr_q;
    mem_dat_d  = mem_dat_q;
    rsp_dat_d  = rsp_dat_q;
    rsp_vld_d  = 1'b0;
    pop        = 1'b0;
`ifdef MEM_TGL_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      StSync: begin
        if (mem_ack == mem_req_q) state_d = StIdle;
      end
      StIdle: begin
        if (!empty) begin
          pop = 1'b1;
          {mem_wr_d, mem_addr_d, mem_dat_d} = fifo_q[rd_ptr_q[FIFO_LOG2-1:0]];
          mem_req_d = !mem_req_q;
          state_d   = StWait;
`ifdef MEM_TGL_TIMEOUT_EN
          cnt_d     = 8'd0;
`endif
        end
      end
      StWait: begin
        if (mem_ack == mem_req_q) begin
          if (!mem_wr_q) begin
            rsp_dat_d = mem_rdat;
            rsp_vld_d = 1'b1;
          end
          state_d = StIdle;
        end
`ifdef MEM_TGL_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT)) begin
          // Cancel by matching req to ack so the next transaction starts from a clean state.
          err_d     = 1'b1;
          mem_req_d = mem_ack;
          if (!mem_wr_q) begin
            rsp_dat_d = '1;
            rsp_vld_d = 1'b1;
          end
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = StSync;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StSync;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_req_q  <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_dat_q  <= '0;
      rsp_dat_q  <= '0;
      rsp_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_dat_q  <= mem_dat_d;
      rsp_dat_q  <= rsp_dat_d;
      rsp_vld_q  <= rsp_vld_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(negedge clk) begin
    if (push) fifo_q[wr_ptr_q[FIFO_LOG2-1:0]] <= {cmd_we, cmd_addr, cmd_dat};
  end

`ifdef MEM_TGL_TIMEOUT_EN
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0 && (TIMEOUT != 0);
`endif

  assign mem_req  = mem_req_q;
  assign mem_wr   = mem_wr_q;
  assign mem_addr = mem_addr_q;
  assign mem_dat  = mem_dat_q;
  assign rsp_dat  = rsp_dat_q;
  assign rsp_vld  = rsp_vld_q;
  assign busy     = !empty || (state_q != StIdle);

endmodule

// File: tb/tb_mem_tgl_master.sv
// Scoreboard bench for mem_tgl_master: randomized commands, arbiter model, reference memory.
module tb_mem_tgl_master;

  typedef struct {
    logic        we;
    logic [19:0] addr;
    logic [15:0] dat;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_vld, cmd_we, cmd_rdy;
  logic [19:0] cmd_addr;
  logic [15:0] cmd_dat;
  logic        rsp_vld;
  logic [15:0] rsp_dat;
  logic [19:0] mem_addr;
  logic [15:0] mem_dat;
  logic        mem_wr, mem_req, mem_ack;
  logic [15:0] mem_rdat;
  logic        busy, err_timeout;

  mem_tgl_master dut (
    .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_dat(cmd_dat), .rsp_vld(rsp_vld), .rsp_dat(rsp_dat),
    .mem_addr(mem_addr), .mem_dat(mem_dat), .mem_wr(mem_wr), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_rdat(mem_rdat), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  int          accepted = 0;
  int          issued = 0;
  bit          mon_en = 0;
  bit          arb_en = 0;
  bit          stall = 0;
  bit          tmo_mode = 0;
  bit          err_exp = 0;
  int          fixed_delay = -1;
  txn_t        txn_q[$];
  logic [15:0] rsp_q[$];
  logic [15:0] ref_mem [logic [19:0]];
  logic [15:0] arb_mem [logic [19:0]];

  function automatic logic [15:0] init_val(input logic [19:0] a);
    return a[15:0] ^ 16'hC3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  // Arbiter model: answers a pending request after a random or forced delay.
  bit counting = 0;
  int dly = 0;
  always @(posedge clk) begin
    #2;
    if (mem_req == mem_ack) counting = 0;
    else if (arb_en) begin
      if (!counting) begin
        counting = 1;
        dly = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
      end
      if (!stall) begin
        if (dly == 0) begin
          if (mem_wr) arb_mem[mem_addr] = mem_dat;
          else mem_rdat = arb_mem.exists(mem_addr) ? arb_mem[mem_addr] : init_val(mem_addr);
          mem_ack  = mem_req;
          counting = 0;
        end else dly--;
      end
    end
  end

  // Monitor: pops expected transactions/responses when the DUT presents them.
  logic prev_req = 1'b0, prev_ack = 1'b0, prev_vld = 1'b0;
  txn_t cur, t;
  always @(posedge clk) begin
    if (mon_en) begin
      if (mem_req != prev_req) begin
        if (tmo_mode && (prev_req != prev_ack)) begin
          err_exp = 1;
          check("cancel_req_eq_ack", mem_req == mem_ack, 1);
        end else begin
          check("idle_before_toggle", prev_req == prev_ack, 1);
          if (txn_q.size() == 0) check("unexpected_txn", txn_q.size(), 1);
          else begin
            t = txn_q.pop_front();
            issued++;
            check("txn_wr", mem_wr, t.we);
            check("txn_addr", mem_addr, t.addr);
            check("txn_dat", mem_dat, t.dat);
            cur = t;
          end
        end
      end else if (mem_req != mem_ack) begin
        check("stable_addr", mem_addr, cur.addr);
        check("stable_dat", mem_dat, cur.dat);
        check("stable_wr", mem_wr, cur.we);
      end
      if (rsp_vld) begin
        check("rsp_single_pulse", prev_vld, 0);
        if (rsp_q.size() == 0) check("unexpected_rsp", rsp_q.size(), 1);
        else check("rsp_dat", rsp_dat, rsp_q.pop_front());
      end
      check("cmd_rdy", cmd_rdy, (accepted - issued) < 4);
      check("busy", busy, ((accepted - issued) > 0) || (mem_req != mem_ack));
      check("err_timeout", err_timeout, err_exp);
    end
    prev_req = mem_req;
    prev_ack = mem_ack;
    prev_vld = rsp_vld;
  end

  task automatic push(input logic we, input logic [19:0] a, input logic [15:0] d,
                      input bit tmo);
    int n = 0;
    cmd_vld = 1'b1; cmd_we = we; cmd_addr = a; cmd_dat = d;
    while (!cmd_rdy && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_rdy) begin
      check("push_accept_bound", cmd_rdy, 1);
      cmd_vld = 1'b0;
      return;
    end
    txn_q.push_back('{we: we, addr: a, dat: d});
    if (we) ref_mem[a] = d;
    else if (tmo) rsp_q.push_back(16'hFFFF);
    else rsp_q.push_back(ref_mem.exists(a) ? ref_mem[a] : init_val(a));
    accepted++;
    @(posedge clk); #1;
    cmd_vld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((txn_q.size() != 0 || rsp_q.size() != 0 || mem_req != mem_ack || busy) && n < 3000)
    begin
      @(posedge clk); #1; n++;
    end
    check("drain_bound", n < 3000, 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; mem_ack = 1'b1; mem_rdat = '0;
    cmd_vld = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_dat = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_mem_req", mem_req, 0);
    check("rst_rsp_vld", rsp_vld, 0);
    check("rst_rsp_dat", rsp_dat, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_dat", mem_dat, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_err", err_timeout, 0);
    check("rst_cmd_rdy", cmd_rdy, 1);
    @(posedge clk); #1;
    mon_en = 1;

    // Reset while the arbiter still shows a mismatched ack.
    push(1'b0, 20'h00010, 16'h0, 0);
    repeat (5) @(posedge clk);
    #1 check("sync_holds_req", mem_req, 0);
    mem_ack = 1'b0;
    arb_en  = 1;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("req_toggles_after_sync", mem_req, 1);
    drain();

    fixed_delay = 3;
    push(1'b1, 20'h12345, 16'hBEEF, 0);
    drain();
    fixed_delay = -1;

    arb_mem[20'h2] = 16'hA55A;
    ref_mem[20'h2] = 16'hA55A;
    push(1'b0, 20'h00002, 16'h0, 0);
    drain();
    check("read_a55a", rsp_dat, 16'hA55A);

    // Stalled arbiter: one in flight plus four queued fills the FIFO.
    stall = 1;
    for (int i = 0; i < 5; i++) push(1'(i & 1), 20'(i + 3), 16'(16'h1000 + i), 0);
    check("full_after_fill", cmd_rdy, 0);
    repeat (3) @(posedge clk);
    stall = 0;
    drain();

    // Occupancy around three with pops overlapping pushes.
    stall = 1;
    for (int i = 0; i < 4; i++) push(1'b0, 20'(i), 16'h0, 0);
    stall = 0;
    fixed_delay = 0;
    for (int i = 0; i < 6; i++) push(1'(i % 3 == 0), 20'(i), 16'(16'h2200 + i), 0);
    drain();
    fixed_delay = -1;

    for (int i = 0; i < 80; i++) begin
      push(1'($urandom_range(0, 1)), 20'($urandom_range(0, 15)), 16'($urandom), 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
    drain();

`ifdef MEM_TGL_TIMEOUT_EN
    stall    = 1;
    tmo_mode = 1;
    push(1'b0, 20'h00007, 16'h0, 1);
    n = 0;
    while (!err_timeout && n < 400) begin
      @(posedge clk); #1; n++;
    end
    check("timeout_flag", err_timeout, 1);
    check("timeout_req_eq_ack", mem_req == mem_ack, 1);
    drain();
    check("timeout_rsp_dat", rsp_dat, 16'hFFFF);
    stall    = 0;
    tmo_mode = 0;
`endif
    check("final_err_timeout", err_timeout, err_exp);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
